// File: rtl/dram_param_if.sv
// Host-side access bus of the parametrised data RAM: address/control/data in,
// read data and status out.
interface dram_param_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 7
);
    logic [AW-1:0] address;
    logic          we;
    logic          re;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          busy;
    logic          addr_err;
    logic [7:0]    err_cnt;

    // Core-side decode drives the request, reads back data and status
    modport master (
        output address, we, re, din,
        input  dout, busy, addr_err, err_cnt
    );

    // RAM side
    modport slave (
        input  address, we, re, din,
        output dout, busy, addr_err, err_cnt
    );
endinterface

// File: rtl/dram_param.sv
// Parametrised single-port data RAM behind the register-file window.
// Post-reset clear sweep, out-of-range detection with a saturating error
// counter, and either combinational read (read/modify/write in one cycle) or
// registered write-first read for macro mapping.
module dram_param #(
    parameter int unsigned   DW             = 8,
    parameter int unsigned   AW             = 7,
    parameter int unsigned   DEPTH          = 70,
    parameter int unsigned   READ_MODE      = 0,
    parameter int unsigned   CLEAR_ON_RESET = 1,
    parameter logic [DW-1:0] CLEAR_VALUE    = '0
) (
    input  logic          clk,
    input  logic          reset_n,
    dram_param_if.slave   bus
);

    localparam int unsigned IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW      = 8;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [IW-1:0] LAST  = IW'(DEPTH - 1);
    localparam logic [CW-1:0] CMAX  = '1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    state_t          state_q, state_d;
    logic [IW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            addr_err_q, addr_err_d;
    logic [CW-1:0]   err_cnt_q, err_cnt_d;

    logic [DW-1:0]   mem [DEPTH];

    logic            legal_c;
    logic [IW-1:0]   addr_idx_c;
    logic [DW-1:0]   rd_data_c;
    logic            mem_we_c;
    logic [IW-1:0]   mem_waddr_c;
    logic [DW-1:0]   mem_wdata_c;

    // Address decode and raw array read; illegal addresses read as zero
    always_comb begin
        legal_c    = ({1'b0, bus.address} < DEPTH_W);
        addr_idx_c = IW'(bus.address);
        rd_data_c  = legal_c ? mem[addr_idx_c] : '0;
    end

    // Sequencer next state, array write port and error tracking
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_err_d  = 1'b0;
        err_cnt_d   = err_cnt_q;
        mem_we_c    = 1'b0;
        mem_waddr_c = addr_idx_c;
        mem_wdata_c = bus.din;

        unique case (state_q)
            ST_CLEAR: begin
                // reset_n gate keeps the array untouched while reset is held
                mem_we_c    = reset_n;
                mem_waddr_c = cnt_q;
                mem_wdata_c = CLEAR_VALUE;
                if (cnt_q == LAST) begin
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q + IW'(1);
                end
            end
            ST_READY: begin
                // busy_q also covers the first cycle after release without a sweep
                if (!busy_q) begin
                    if (bus.we && legal_c) begin
                        mem_we_c = 1'b1;
                    end
                    if ((bus.we || bus.re) && !legal_c) begin
                        addr_err_d = 1'b1;
                        if (err_cnt_q != CMAX) begin
                            err_cnt_d = err_cnt_q + CW'(1);
                        end
                    end
                end
            end
        endcase

        busy_d = (state_d == ST_CLEAR);
    end

    // Control and status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RST_STATE;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            addr_err_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            addr_err_q <= addr_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Storage array; reset deliberately leaves contents alone
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
    end

    if (READ_MODE != 0) begin : g_sync_rd
        logic [DW-1:0] dout_q, dout_d;

        // Registered read, write-first on a same-address collision
        always_comb begin
            dout_d = dout_q;
            if (busy_q) begin
                dout_d = '0;
            end else if (bus.re) begin
                if (!legal_c) begin
                    dout_d = '0;
                end else if (bus.we) begin
                    dout_d = bus.din;
                end else begin
                    dout_d = rd_data_c;
                end
            end
        end

        // Read data register
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                dout_q <= '0;
            end else begin
                dout_q <= dout_d;
            end
        end

        assign bus.dout = dout_q;
    end else begin : g_async_rd
        // Combinational read shows the pre-edge value, enabling one-cycle RMW
        assign bus.dout = busy_q ? '0 : rd_data_c;
    end

    assign bus.busy     = busy_q;
    assign bus.addr_err = addr_err_q;
    assign bus.err_cnt  = err_cnt_q;

endmodule
